third_task: RTL and testbench
=============================

// Module: third_task
// PURPOSE
//  Sequential squarer: computes Y_ALL = (membr_1 + 1)^2 for an 8-bit unsigned sample.
//  Uses an iterative shift-add multiplier, one bit per clock.
//  Sits behind a sample source that issues single-cycle start strobes.
//  Result feeds downstream consumers via a one-cycle done pulse.
// PARAMETERS
//  DATA_W  8             width of membr_1 (unsigned)
//  OUT_W   2*DATA_W+1    width of Y_ALL; 17 holds the maximum value 256^2 = 65536
// PORTS
//  clk      in   1       single clock; all state updates on its rising edge
//  rst_n    in   1       asynchronous, active-low reset
//  start    in   1       start strobe; sampled only in IDLE
//  membr_1  in   DATA_W  input sample; captured on the accepted start edge
//  busy     out  1       1 while in CALC
//  done     out  1       one-cycle pulse when Y_ALL is updated
//  Y_ALL    out  OUT_W   last result; holds until the next completion
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, Y_ALL=0, done=0, busy=0, internal acc/cnt=0.
//  - FSM states: IDLE, CALC.
//  - IDLE: on start=1 at edge k, load op = {1'b0,membr_1}+1 (DATA_W+1 bits, no overflow).
//    Load mcand = op (OUT_W bits), acc=0, cnt=0; go to CALC.
//  - CALC: each edge adds mcand<<cnt to acc when op[cnt]=1, then cnt++.
//    Bits 0..DATA_W are processed, which is 9 iterations at edges k+1..k+9.
//  - Final CALC edge (k+9): Y_ALL <= final acc, done=1 for that cycle only, state=IDLE.
//  - Latency: start edge to done-high is exactly DATA_W+1 = 9 cycles.
//  - Back-to-back: start may be reissued in the cycle where done=1. It is accepted,
//    because the state is IDLE.
//  - start while busy: ignored; membr_1 changes during CALC have no effect.
//  - Width: acc is OUT_W bits; the maximum 65536 (membr_1=255) fits exactly, with no saturation.
//  - Reset mid-CALC: computation aborted, Y_ALL cleared to 0, no done pulse.
//  - done and busy are never both 1. done is registered, with no combinational path
//    from inputs to outputs.
// STRUCTURE
//  - Shared package third_task_pkg holds DATA_W, OUT_W and the state enum {IDLE, CALC}.
//  - One sub-module is natural: shift_add_mult_seq, a generic iterative unsigned multiplier.
//    It takes start/a/b and returns done/p.
//  - third_task adds the +1 pre-increment, feeds op to both multiplier inputs,
//    and registers Y_ALL.
// TESTING
//  1. Reset, then membr_1=0, start -> done after 9 cycles, Y_ALL=1.
//  2. Sequence membr_1=1,2,3, each started after the previous done -> Y_ALL=4, 9, 16.
//  3. Sequence membr_1=4,5,6 issued back-to-back on the done cycle -> Y_ALL=25, 36, 49;
//     there are no idle gaps.
//  4. membr_1=255 -> Y_ALL=65536 (bit 16 set, bits 15:0 zero).
//  5. Start membr_1=3, then pulse start with membr_1=9 during CALC -> single done, Y_ALL=16.
//  6. Start membr_1=7, then assert rst_n=0 at cycle 4 -> Y_ALL=0, busy=0, no done.
//     After release, start with 7 -> Y_ALL=64.

Source files
------------

// File: rtl/third_task_pkg.sv
// Shared widths and FSM encoding for the (membr_1+1)^2 squarer and its multiplier.
// Combinational definitions only; no latency, no flow control.
package third_task_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = DATA_W + 1;
    localparam int OUT_W  = 2 * DATA_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;
endpackage

// File: rtl/third_task_if.sv
// Sample/result bundle between the sample source (master) and the squarer (slave).
// Start is a single-cycle strobe; done is a one-cycle pulse; no other flow control.
interface third_task_if;
    import third_task_pkg::*;

    logic              start;
    logic [DATA_W-1:0] membr_1;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  Y_ALL;

    modport master (
        output start,
        output membr_1,
        input  busy,
        input  done,
        input  Y_ALL
    );

    modport slave (
        input  start,
        input  membr_1,
        output busy,
        output done,
        output Y_ALL
    );
endinterface

// File: rtl/third_task_shift_add_mult_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock, A_W cycles per product.
// start_i is only honoured while idle; done_o/p_o are valid during the final iteration cycle.
module shift_add_mult_seq
    import third_task_pkg::*;
#(
    parameter int A_W = 9,
    parameter int P_W = 2 * A_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [A_W-1:0] a_i,
    input  logic [A_W-1:0] b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [P_W-1:0] p_o
);
    localparam int CNT_W = $clog2(A_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(A_W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [P_W-1:0]   mcand_q, mcand_d;
    logic [A_W-1:0]   mplier_q, mplier_d;
    logic [P_W-1:0]   addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        addend   = '0;
        done_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = P_W'(a_i);
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[cnt_q]) begin
                    addend = mcand_q << cnt_q;
                end
                acc_d = acc_q + addend;
                cnt_d = cnt_q + CNT_W'(1);
                // Final bit: hand the finished sum to the caller this cycle.
                if (cnt_q == LAST_CNT) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p_o    = acc_d;
    assign busy_o = (state_q == CALC);
endmodule

// File: rtl/third_task.sv
// Sequential squarer Y_ALL = (membr_1+1)^2; done pulses 9 cycles after the accepted start edge.
// Starts arriving while busy are dropped; Y_ALL holds until the next completion.
module third_task
    import third_task_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    third_task_if.slave bus
);
    logic [OP_W-1:0]  op;
    logic             mult_busy;
    logic             mult_done;
    logic [OUT_W-1:0] mult_p;
    logic [OUT_W-1:0] y_all_q, y_all_d;
    logic             done_q, done_d;

    // Nine-bit operand so that 255+1 does not wrap.
    assign op = {1'b0, bus.membr_1} + OP_W'(1);

    shift_add_mult_seq #(
        .A_W (OP_W),
        .P_W (OUT_W)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (bus.start),
        .a_i     (op),
        .b_i     (op),
        .busy_o  (mult_busy),
        .done_o  (mult_done),
        .p_o     (mult_p)
    );

    always_comb begin
        y_all_d = y_all_q;
        done_d  = mult_done;
        if (mult_done) begin
            y_all_d = mult_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_all_q <= '0;
            done_q  <= 1'b0;
        end else begin
            y_all_q <= y_all_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = mult_busy;
    assign bus.done  = done_q;
    assign bus.Y_ALL = y_all_q;
endmodule

// File: tb/tb_third_task.sv
// Directed bench for third_task: reset, latency, back-to-back, max value, ignored start, mid-run reset.
module tb_third_task;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    third_task_if bus ();

    third_task dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe start for exactly one edge, then scramble membr_1 to prove it was captured.
    task automatic issue(input logic [7:0] m);
        bus.start   = 1'b1;
        bus.membr_1 = m;
        tick();
        bus.start   = 1'b0;
        bus.membr_1 = 8'hA5;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [16:0] exp_y);
        int n;
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_y"}, bus.Y_ALL, exp_y);
        chk({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic count_done(input string tag, input int cycles, input int exp_cnt);
        int c;
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done) c++;
            tick();
        end
        chk(tag, c, exp_cnt);
    endtask

    initial begin
        logic [16:0] y_max;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.membr_1 = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_y", bus.Y_ALL, 17'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: membr_1=0 -> 1, done lasts one cycle
        issue(8'd0);
        chk("t1_busy_after_start", bus.busy, 1'b1);
        wait_done("t1", 9, 17'd1);
        tick();
        chk("t1_done_one_cycle", bus.done, 1'b0);
        chk("t1_y_hold", bus.Y_ALL, 17'd1);

        // 2: spaced starts
        tick();
        issue(8'd1);
        chk("t2_y_hold_during_calc", bus.Y_ALL, 17'd1);
        wait_done("t2a", 9, 17'd4);
        tick();
        issue(8'd2);
        wait_done("t2b", 9, 17'd9);
        tick();
        issue(8'd3);
        wait_done("t2c", 9, 17'd16);
        tick();

        // 3: back-to-back on the done cycle
        issue(8'd4);
        wait_done("t3a", 9, 17'd25);
        issue(8'd5);
        chk("t3_busy_no_gap", bus.busy, 1'b1);
        wait_done("t3b", 9, 17'd36);
        issue(8'd6);
        wait_done("t3c", 9, 17'd49);
        tick();

        // 4: maximum value
        issue(8'd255);
        wait_done("t4", 9, 17'd65536);
        y_max = bus.Y_ALL;
        chk("t4_bit16", y_max[16], 1'b1);
        chk("t4_low16", y_max[15:0], 16'd0);
        tick();

        // 5: start during CALC is ignored
        issue(8'd3);
        tick();
        tick();
        bus.start   = 1'b1;
        bus.membr_1 = 8'd9;
        tick();
        bus.start   = 1'b0;
        chk("t5_busy_mid", bus.busy, 1'b1);
        wait_done("t5", 6, 17'd16);
        tick();
        count_done("t5_single_done", 15, 0);

        // 6: reset mid-CALC
        issue(8'd7);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_y", bus.Y_ALL, 17'd0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_done", bus.done, 1'b0);
        tick();
        rst_n = 1'b1;
        count_done("t6_no_done", 12, 0);
        chk("t6_y_after", bus.Y_ALL, 17'd0);
        issue(8'd7);
        wait_done("t6_restart", 9, 17'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
